button_gesture_detector: RTL and testbench
==========================================

Name: button_gesture_detector

Overview:
Consumes the debounced button level produced by the upstream debouncer stage and classifies each user gesture. A gesture is one of three kinds: short press, long press, or double press. Each classification produces a single-cycle event pulse, and the block keeps a running count of all events. It sits between the debouncer and the application control logic, e.g. a mode or menu FSM.

Parameters:
LONG_CYCLES, 20'd1000000, hold length that qualifies as a long press (sampled cycles minus one, see Behaviour); legal range >= 2
GAP_CYCLES, 20'd250000, maximum low time after a first release in which a second press makes a double press; legal range >= 1
CNT_W, 20, width of the internal timer; must hold max(LONG_CYCLES, GAP_CYCLES)

Ports:
i_clk  input  1  system clock; all logic on posedge
i_rst  input  1  synchronous, active-high reset
i_data  input  1  debounced button level, 1 = pressed, already synchronous to i_clk
o_short  output  1  one-cycle pulse: short press recognised
o_long  output  1  one-cycle pulse: long press recognised
o_double  output  1  one-cycle pulse: double press recognised
o_busy  output  1  high whenever the FSM is not IDLE
o_event_count  output  8  count of all emitted events, wraps 255 -> 0

Behaviour:
- Edge detection
  - r_prev <= i_data every cycle.
  - rise = i_data & ~r_prev; fall = ~i_data & r_prev.
- Reset (synchronous): state = IDLE, timer = 0, r_prev = 1, all pulses = 0, o_event_count = 0, o_busy = 0.
  - Setting r_prev = 1 means a button already held at reset release is not a press. A rise is needed only after a low sample.
- Registered outputs: all outputs are registered. A pulse decided at posedge Ek is high for exactly the cycle after Ek. Pulses are mutually exclusive.
- FSM states: IDLE, PRESSED, WAIT_SECOND, SECOND_PRESSED, HOLD.
- IDLE
  - rise -> PRESSED, timer = 0.
- PRESSED (check fall first)
  - fall -> WAIT_SECOND, timer = 0.
  - else if timer == LONG_CYCLES-1 -> o_long, go HOLD.
  - else timer++.
  - Net effect: o_long fires at the edge where i_data has been sampled high LONG_CYCLES+1 consecutive times, counting the rise sample.
- HOLD
  - Ignore everything until fall, then -> IDLE.
  - No event on release of a long press.
- WAIT_SECOND (check rise first)
  - rise -> SECOND_PRESSED.
  - else if timer == GAP_CYCLES-1 -> o_short, go IDLE.
  - else timer++.
- SECOND_PRESSED
  - fall -> o_double, go IDLE.
  - Second-press duration is irrelevant: no long detection here and no timer use.
- Simultaneous conditions
  - Rise in WAIT_SECOND on the same edge the gap would expire: rise wins, the result is a double.
  - Fall in PRESSED on the same edge long would fire: fall wins, the press is treated as short/double-candidate.
- o_event_count increments by 1 on the same edge any pulse is set, modulo 256.
- o_busy = (state != IDLE), registered alongside state.
- Reset asserted in any state aborts the gesture immediately. No pulse is emitted for it.
- Timer never exceeds max(LONG_CYCLES, GAP_CYCLES)-1. No wrap is possible.

Test Plan:
(Bench parameters: LONG_CYCLES=10, GAP_CYCLES=6.)
- Short press: i_data high 3 samples, then low -> o_short pulses once, in the cycle after the 7th low sample. o_event_count = 1, o_busy drops with it.
- Double press: high 3, low 2, high 2, low -> o_double pulses in the cycle after the final low sample. No o_short. Count = 1.
- Long press: high 11 consecutive samples -> o_long after the 11th sample. Hold to 30 samples, then release -> no further pulses, FSM back in IDLE. High exactly 10 samples then low -> no o_long; o_short follows after the gap.
- Tie cases:
  - Re-press on the 7th low sample (gap expiry edge) -> o_double, not o_short.
  - Release on the 11th sample -> no o_long.
- Reset behaviour:
  - i_rst in PRESSED after 5 high samples -> no pulses, o_busy = 0, count = 0.
  - i_data held high through reset release -> no press is detected until a low-then-high sequence occurs.
- Counter wrap: 256 short presses -> o_event_count steps 254, 255, 0. Exactly one pulse per gesture.

Source files
------------

// File: rtl/button_gesture_detector_if.sv
// Signal bundle between the debouncer-facing gesture detector and its consumer:
// debounced level in, event pulses and status out.
interface button_gesture_detector_if;
    logic       i_data;
    logic       o_short;
    logic       o_long;
    logic       o_double;
    logic       o_busy;
    logic [7:0] o_event_count;

    modport master (
        output i_data,
        input  o_short, o_long, o_double, o_busy, o_event_count
    );

    modport slave (
        input  i_data,
        output o_short, o_long, o_double, o_busy, o_event_count
    );
endinterface

// File: rtl/button_gesture_detector.sv
// Classifies debounced button activity into short, long and double presses,
// emitting one registered pulse per gesture and keeping a wrapping event count.
module button_gesture_detector #(
    parameter int unsigned LONG_CYCLES = 20'd1000000,
    parameter int unsigned GAP_CYCLES  = 20'd250000,
    parameter int unsigned CNT_W       = 20
) (
    input logic                      i_clk,
    input logic                      i_rst,
    button_gesture_detector_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        WAIT_SECOND,
        SECOND_PRESSED,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic             r_prev;
    logic             short_q, long_q, double_q, busy_q;
    logic             short_n, long_n, double_n;
    logic [7:0]       count_q, count_n;
    logic             rise, fall;

    assign rise = bus.i_data & ~r_prev;
    assign fall = ~bus.i_data & r_prev;

    // r_prev resets high so a button held across reset release is not a press.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            timer    <= '0;
            r_prev   <= 1'b1;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            busy_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            r_prev   <= bus.i_data;
            short_q  <= short_n;
            long_q   <= long_n;
            double_q <= double_n;
            busy_q   <= (state_n != IDLE);
            count_q  <= count_n;
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        short_n  = 1'b0;
        long_n   = 1'b0;
        double_n = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = PRESSED;
                    timer_n = '0;
                end
            end
            // Release beats long-press expiry on the same edge.
            PRESSED: begin
                if (fall) begin
                    state_n = WAIT_SECOND;
                    timer_n = '0;
                end else if (timer == LONG_LAST) begin
                    long_n  = 1'b1;
                    state_n = HOLD;
                end else begin
                    timer_n = timer + CNT_W'(1);
                end
            end
            HOLD: begin
                if (fall) begin
                    state_n = IDLE;
                end
            end
            // Re-press beats gap expiry on the same edge.
            WAIT_SECOND: begin
                if (rise) begin
                    state_n = SECOND_PRESSED;
                end else if (timer == GAP_LAST) begin
                    short_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + CNT_W'(1);
                end
            end
            SECOND_PRESSED: begin
                if (fall) begin
                    double_n = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        count_n = count_q + 8'(short_n | long_n | double_n);
    end

    assign bus.o_short       = short_q;
    assign bus.o_long        = long_q;
    assign bus.o_double      = double_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_event_count = count_q;

endmodule

// File: tb/tb_button_gesture_detector.sv
// Self-checking bench: directed gesture scenarios plus a randomized run-length
// stream checked against a gesture-level reference model.
module tb_button_gesture_detector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_count = 0;

    button_gesture_detector_if bus();

    button_gesture_detector #(
        .LONG_CYCLES(10),
        .GAP_CYCLES (6),
        .CNT_W      (20)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] pulses();
        return {bus.o_short, bus.o_long, bus.o_double};
    endfunction

    // Drive one sample, let the edge take it, then settle past the edge.
    task automatic step(input logic d);
        bus.i_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_data = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_count = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_data = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (pulses() !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_pulses: got %b expected 000", pulses());
        end
        vectors++;
        if (bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0", bus.o_busy);
        end
        vectors++;
        if (bus.o_event_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d expected 0", bus.o_event_count);
        end
        rst = 1'b0;
        exp_count = 0;
    endtask

    task automatic test_short();
        logic [2:0] exp;
        step(0);
        step(0);
        repeat (3) step(1);
        vectors++;
        if (bus.o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL short_busy_high: got %b expected 1", bus.o_busy);
        end
        for (int i = 1; i <= 7; i++) begin
            step(0);
            exp = (i == 7) ? 3'b100 : 3'b000;
            vectors++;
            if (pulses() !== exp) begin
                miscompares++;
                $display("FAIL short_low%0d: got %b expected %b", i, pulses(), exp);
            end
        end
        exp_count++;
        vectors++;
        if (bus.o_event_count !== 8'(exp_count) || bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL short_count_busy: got %0d/%b expected %0d/0",
                     bus.o_event_count, bus.o_busy, exp_count);
        end
        step(0);
        vectors++;
        if (pulses() !== 3'b000) begin
            miscompares++;
            $display("FAIL short_single: got %b expected 000", pulses());
        end
    endtask

    task automatic test_double();
        logic seq [7] = '{1, 1, 1, 0, 0, 1, 1};
        for (int i = 0; i < 7; i++) begin
            step(seq[i]);
            vectors++;
            if (pulses() !== 3'b000) begin
                miscompares++;
                $display("FAIL double_pre%0d: got %b expected 000", i, pulses());
            end
        end
        step(0);
        exp_count++;
        vectors++;
        if (pulses() !== 3'b001 || bus.o_event_count !== 8'(exp_count)) begin
            miscompares++;
            $display("FAIL double_fire: got %b/%0d expected 001/%0d",
                     pulses(), bus.o_event_count, exp_count);
        end
        repeat (8) begin
            step(0);
            vectors++;
            if (pulses() !== 3'b000) begin
                miscompares++;
                $display("FAIL double_after: got %b expected 000", pulses());
            end
        end
    endtask

    task automatic test_long();
        logic [2:0] exp;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            exp = (i == 11) ? 3'b010 : 3'b000;
            vectors++;
            if (pulses() !== exp) begin
                miscompares++;
                $display("FAIL long_high%0d: got %b expected %b", i, pulses(), exp);
            end
        end
        exp_count++;
        for (int i = 1; i <= 8; i++) begin
            step(0);
            vectors++;
            if (pulses() !== 3'b000 || bus.o_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL long_release%0d: got %b/%b expected 000/0",
                         i, pulses(), bus.o_busy);
            end
        end
        // Release on the 11th sample: short, never long.
        for (int i = 1; i <= 17; i++) begin
            step(i <= 10);
            exp = (i == 17) ? 3'b100 : 3'b000;
            vectors++;
            if (pulses() !== exp) begin
                miscompares++;
                $display("FAIL long_tie%0d: got %b expected %b", i, pulses(), exp);
            end
        end
        exp_count++;
        vectors++;
        if (bus.o_event_count !== 8'(exp_count)) begin
            miscompares++;
            $display("FAIL long_count: got %0d expected %0d", bus.o_event_count, exp_count);
        end
    endtask

    task automatic test_gap_tie();
        step(0);
        repeat (3) step(1);
        for (int i = 1; i <= 6; i++) step(0);
        step(1);
        vectors++;
        if (pulses() !== 3'b000 || bus.o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_tie_repress: got %b/%b expected 000/1", pulses(), bus.o_busy);
        end
        step(1);
        step(0);
        exp_count++;
        vectors++;
        if (pulses() !== 3'b001 || bus.o_event_count !== 8'(exp_count)) begin
            miscompares++;
            $display("FAIL gap_tie_double: got %b/%0d expected 001/%0d",
                     pulses(), bus.o_event_count, exp_count);
        end
    endtask

    task automatic test_reset_mid();
        step(0);
        repeat (5) step(1);
        rst = 1'b1;
        step(1);
        vectors++;
        if (pulses() !== 3'b000 || bus.o_busy !== 1'b0 || bus.o_event_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got %b/%b/%0d expected 000/0/0",
                     pulses(), bus.o_busy, bus.o_event_count);
        end
        rst = 1'b0;
        exp_count = 0;
        for (int i = 1; i <= 15; i++) begin
            step(1);
            vectors++;
            if (pulses() !== 3'b000 || bus.o_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL held_through_reset%0d: got %b/%b expected 000/0",
                         i, pulses(), bus.o_busy);
            end
        end
        step(0);
        step(1);
        vectors++;
        if (bus.o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL press_after_low: got busy %b expected 1", bus.o_busy);
        end
        repeat (7) step(0);
        exp_count++;
        vectors++;
        if (pulses() !== 3'b100 || bus.o_event_count !== 8'(exp_count)) begin
            miscompares++;
            $display("FAIL reset_recover: got %b/%0d expected 100/%0d",
                     pulses(), bus.o_event_count, exp_count);
        end
    endtask

    task automatic test_wrap();
        int shorts, total;
        do_reset();
        step(0);
        for (int g = 0; g < 256; g++) begin
            shorts = 0;
            total  = 0;
            step(1);
            total += int'(bus.o_short) + int'(bus.o_long) + int'(bus.o_double);
            for (int i = 0; i < 7; i++) begin
                step(0);
                shorts += int'(bus.o_short);
                total  += int'(bus.o_short) + int'(bus.o_long) + int'(bus.o_double);
            end
            exp_count = (exp_count + 1) % 256;
            vectors++;
            if (shorts != 1 || total != 1 || bus.o_event_count !== 8'(exp_count)) begin
                miscompares++;
                $display("FAIL wrap_g%0d: got shorts=%0d total=%0d count=%0d expected 1/1/%0d",
                         g, shorts, total, bus.o_event_count, exp_count);
            end
        end
    endtask

    // Reference model works on whole high/low runs, not individual samples.
    task automatic test_random();
        logic       stim[$];
        logic [2:0] ev[$];
        int         h, l, s;
        bit         pending;
        logic [2:0] exp;
        do_reset();
        pending = 0;
        repeat (3) begin stim.push_back(0); ev.push_back(3'b000); end
        for (int g = 0; g < 60; g++) begin
            h = $urandom_range(1, 16);
            l = (g == 59) ? 10 : $urandom_range(1, 9);
            s = stim.size();
            repeat (h) begin stim.push_back(1); ev.push_back(3'b000); end
            repeat (l) begin stim.push_back(0); ev.push_back(3'b000); end
            if (pending) begin
                ev[s + h] = 3'b001;
                pending = 0;
            end else if (h >= 11) begin
                ev[s + 10] = 3'b010;
            end else if (l >= 7) begin
                ev[s + h + 6] = 3'b100;
            end else begin
                pending = 1;
            end
        end
        for (int k = 0; k < stim.size(); k++) begin
            step(stim[k]);
            exp = ev[k];
            if (exp != 3'b000) exp_count = (exp_count + 1) % 256;
            vectors++;
            if (pulses() !== exp || bus.o_event_count !== 8'(exp_count)) begin
                miscompares++;
                $display("FAIL random_k%0d: got %b/%0d expected %b/%0d",
                         k, pulses(), bus.o_event_count, exp, exp_count);
            end
        end
        vectors++;
        if (bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL random_idle: got busy %b expected 0", bus.o_busy);
        end
    endtask

    initial begin
        bus.i_data = 1'b0;
        test_reset();
        test_short();
        test_double();
        test_long();
        test_gap_tie();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
